// File: rtl/an_sec_pkg.sv
// Shared types and arithmetic for the AN-code single-error-correcting decoder.
// The modular helper works on a fixed 32-bit container; callers truncate to RW bits.
package an_sec_pkg;

    typedef enum logic [2:0] {IDLE, REM, SEARCH, CORR, DONE} state_e;

    localparam logic [1:0] ST_CLEAN   = 2'b00;
    localparam logic [1:0] ST_CORR    = 2'b01;
    localparam logic [1:0] ST_NOMATCH = 2'b10;
    localparam logic [1:0] ST_RANGE   = 2'b11;

    // (2r + b) mod a for r < a; one conditional subtract suffices since 2r+b < 2a
    function automatic logic [31:0] mod_dbl_add(input logic [31:0] r,
                                                input logic        b,
                                                input logic [31:0] a);
        logic [32:0] t;
        t = {r, 1'b0} + {32'd0, b};
        if (t >= {1'b0, a})
            t = t - {1'b0, a};
        return t[31:0];
    endfunction

endpackage

// File: rtl/an_sec_serial_decoder_rem.sv
// Bit-serial Horner remainder engine: r <= (2r + b) mod A, MSB first.
// rem_nxt_o exposes the value r will take at the next edge.
module an_serial_rem
    import an_sec_pkg::*;
#(
    parameter int A_CONST = 17619,
    parameter int RW      = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_i,
    input  logic          bit_vld_i,
    input  logic          bit_i,
    input  logic          last_i,
    output logic [RW-1:0] rem_o,
    output logic [RW-1:0] rem_nxt_o,
    output logic          done_o
);

    logic [RW-1:0] rem_q, rem_d;

    always_comb begin
        rem_d = rem_q;
        if (start_i)
            rem_d = '0;
        else if (bit_vld_i)
            rem_d = RW'(mod_dbl_add(32'(rem_q), bit_i, 32'(A_CONST)));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rem_q <= '0;
        else     rem_q <= rem_d;
    end

    assign rem_o     = rem_q;
    assign rem_nxt_o = rem_d;
    assign done_o    = bit_vld_i & last_i;

endmodule

// File: rtl/an_sec_serial_decoder.sv
// Sequential single-error-correcting AN-code decoder: serial remainder, then an
// iterative search of +/-2^(i-1) mod A, then a range-checked correction.
module an_sec_serial_decoder
    import an_sec_pkg::*;
#(
    parameter int A_CONST = 17619,
    parameter int N       = 43,
    parameter int RW      = 15,
    parameter int LW      = 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_cw,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_cw,
    output logic [LW-1:0] out_loc,
    output logic [RW-1:0] out_rem,
    output logic [1:0]    out_status
);

    localparam int CW = $clog2(N + 1);

    state_e        state_q, state_d;
    logic [N-1:0]  sr_q, sr_d, hold_q, hold_d, ocw_q, ocw_d;
    logic [CW-1:0] cnt_q, cnt_d, i_q, i_d;
    logic [RW-1:0] p_q, p_d, q_q, q_d;
    logic [LW-1:0] loc_q, loc_d;
    logic [1:0]    st_q, st_d;
    logic          neg_q, neg_d;

    logic          start, bit_vld, rem_done;
    logic [RW-1:0] rem, rem_nxt;
    logic [N:0]    pw, sum;

    an_serial_rem #(.A_CONST(A_CONST), .RW(RW)) u_rem (
        .clk       (clk),
        .rst       (rst),
        .start_i   (start),
        .bit_vld_i (bit_vld),
        .bit_i     (sr_q[N-1]),
        .last_i    (cnt_q == '0),
        .rem_o     (rem),
        .rem_nxt_o (rem_nxt),
        .done_o    (rem_done)
    );

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        hold_d  = hold_q;
        ocw_d   = ocw_q;
        cnt_d   = cnt_q;
        i_d     = i_q;
        p_d     = p_q;
        q_d     = q_q;
        loc_d   = loc_q;
        st_d    = st_q;
        neg_d   = neg_q;
        start   = 1'b0;
        bit_vld = 1'b0;
        pw      = (N+1)'(1) << (i_q - CW'(1));
        sum     = '0;
        unique case (state_q)
            IDLE: if (in_valid) begin
                sr_d    = in_cw;
                hold_d  = in_cw;
                cnt_d   = CW'(N - 1);
                start   = 1'b1;
                state_d = REM;
            end
            REM: begin
                bit_vld = 1'b1;
                sr_d    = sr_q << 1;
                cnt_d   = cnt_q - CW'(1);
                if (rem_done) begin
                    if (rem_nxt == '0) begin
                        st_d    = ST_CLEAN;
                        loc_d   = '0;
                        ocw_d   = hold_q;
                        state_d = DONE;
                    end else begin
                        i_d     = CW'(1);
                        p_d     = RW'(1);
                        q_d     = RW'(A_CONST) - rem_nxt;
                        state_d = SEARCH;
                    end
                end
            end
            SEARCH: begin
                // +i wins if both ever match
                if (p_q == rem) begin
                    loc_d   = LW'(i_q);
                    neg_d   = 1'b0;
                    state_d = CORR;
                end else if (p_q == q_q) begin
                    loc_d   = -LW'(i_q);
                    neg_d   = 1'b1;
                    state_d = CORR;
                end else if (i_q == CW'(N)) begin
                    st_d    = ST_NOMATCH;
                    loc_d   = '0;
                    ocw_d   = hold_q;
                    state_d = DONE;
                end else begin
                    p_d = RW'(mod_dbl_add(32'(p_q), 1'b0, 32'(A_CONST)));
                    i_d = i_q + CW'(1);
                end
            end
            CORR: begin
                // bit N of the N+1-bit result flags both underflow and overflow
                sum = neg_q ? ({1'b0, hold_q} + pw) : ({1'b0, hold_q} - pw);
                if (sum[N]) begin
                    st_d  = ST_RANGE;
                    ocw_d = hold_q;
                end else begin
                    st_d  = ST_CORR;
                    ocw_d = sum[N-1:0];
                end
                state_d = DONE;
            end
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sr_q    <= '0;
            hold_q  <= '0;
            ocw_q   <= '0;
            cnt_q   <= '0;
            i_q     <= '0;
            p_q     <= '0;
            q_q     <= '0;
            loc_q   <= '0;
            st_q    <= ST_CLEAN;
            neg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            hold_q  <= hold_d;
            ocw_q   <= ocw_d;
            cnt_q   <= cnt_d;
            i_q     <= i_d;
            p_q     <= p_d;
            q_q     <= q_d;
            loc_q   <= loc_d;
            st_q    <= st_d;
            neg_q   <= neg_d;
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == DONE);
    assign out_cw     = ocw_q;
    assign out_loc    = loc_q;
    assign out_rem    = rem;
    assign out_status = st_q;

endmodule

// File: tb/tb_an_sec_serial_decoder.sv
// Directed bench for the AN-code decoder using hand-computed vectors for A=17619, N=43.
module tb_an_sec_serial_decoder;

    localparam int N  = 43;
    localparam int RW = 15;
    localparam int LW = 7;

    logic          clk, rst, in_valid, in_ready, out_valid, out_ready;
    logic [N-1:0]  in_cw, out_cw;
    logic [LW-1:0] out_loc;
    logic [RW-1:0] out_rem;
    logic [1:0]    out_status;

    int checks = 0;
    int errors = 0;

    an_sec_serial_decoder #(.A_CONST(17619), .N(N), .RW(RW), .LW(LW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_cw(in_cw),
        .out_valid(out_valid), .out_ready(out_ready), .out_cw(out_cw), .out_loc(out_loc),
        .out_rem(out_rem), .out_status(out_status)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // lat counts cycles from the accept cycle T to the first cycle with out_valid high
    task automatic run_word(input logic [N-1:0] cw, output int lat);
        int w;
        w = 0;
        while (!in_ready && w < 200) begin @(posedge clk); #1; w++; end
        in_valid = 1; in_cw = cw;
        @(posedge clk); #1;
        in_valid = 0;
        lat = 1;
        while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
        if (!out_valid) lat = -1;
    endtask

    task automatic ack();
        out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0;
    endtask

    task automatic test_reset();
        rst = 1; in_valid = 0; in_cw = '0; out_ready = 0;
        #12;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_cw !== '0 || out_loc !== '0 ||
            out_rem !== '0 || out_status !== 2'b00) begin
            errors++;
            $display("FAIL reset: v=%b rdy=%b cw=%0d loc=%0d rem=%0d st=%b, need 0 1 0 0 0 00",
                     out_valid, in_ready, out_cw, out_loc, out_rem, out_status);
        end
        @(posedge clk); #1; rst = 0;
    endtask

    task automatic test_clean();
        int lat;
        run_word(43'd88095, lat);
        checks++; if (lat !== 44) begin errors++; $display("FAIL clean_lat: got %0d need 44", lat); end
        checks++; if (out_rem !== 15'd0) begin errors++; $display("FAIL clean_rem: got %0d need 0", out_rem); end
        checks++; if (out_status !== 2'b00 || out_loc !== 7'd0) begin errors++;
            $display("FAIL clean_st: got st=%b loc=%0d need 00 0", out_status, out_loc); end
        checks++; if (out_cw !== 43'd88095) begin errors++; $display("FAIL clean_cw: got %0d need 88095", out_cw); end
        ack();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++;
            $display("FAIL clean_ack: got v=%b rdy=%b need 0 1", out_valid, in_ready); end
    endtask

    task automatic test_pos_error();
        int lat;
        run_word(43'd120863, lat);
        checks++; if (lat !== 61) begin errors++; $display("FAIL pos_lat: got %0d need 61", lat); end
        checks++; if (out_rem !== 15'd15149) begin errors++; $display("FAIL pos_rem: got %0d need 15149", out_rem); end
        checks++; if (out_status !== 2'b01 || out_loc !== 7'd16) begin errors++;
            $display("FAIL pos_st: got st=%b loc=%0d need 01 16", out_status, out_loc); end
        checks++; if (out_cw !== 43'd88095) begin errors++; $display("FAIL pos_cw: got %0d need 88095", out_cw); end
        // consumer stalls: everything must hold
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_cw !== 43'd88095 ||
                out_loc !== 7'd16 || out_status !== 2'b01 || out_rem !== 15'd15149) begin
                errors++;
                $display("FAIL hold_%0d: got v=%b rdy=%b cw=%0d loc=%0d st=%b rem=%0d", k,
                         out_valid, in_ready, out_cw, out_loc, out_status, out_rem);
            end
        end
        ack();
    endtask

    task automatic test_neg_error();
        int lat;
        run_word(43'd88094, lat);
        checks++; if (lat !== 46) begin errors++; $display("FAIL neg_lat: got %0d need 46", lat); end
        checks++; if (out_rem !== 15'd17618) begin errors++; $display("FAIL neg_rem: got %0d need 17618", out_rem); end
        checks++; if (out_status !== 2'b01 || out_loc !== 7'h7f) begin errors++;
            $display("FAIL neg_st: got st=%b loc=%h need 01 7f", out_status, out_loc); end
        checks++; if (out_cw !== 43'd88095) begin errors++; $display("FAIL neg_cw: got %0d need 88095", out_cw); end
        ack();
    endtask

    task automatic test_nomatch();
        int lat;
        run_word(43'd88098, lat);
        checks++; if (lat !== 87) begin errors++; $display("FAIL nomatch_lat: got %0d need 87", lat); end
        checks++; if (out_rem !== 15'd3) begin errors++; $display("FAIL nomatch_rem: got %0d need 3", out_rem); end
        checks++; if (out_status !== 2'b10 || out_loc !== 7'd0) begin errors++;
            $display("FAIL nomatch_st: got st=%b loc=%0d need 10 0", out_status, out_loc); end
        checks++; if (out_cw !== 43'd88098) begin errors++; $display("FAIL nomatch_cw: got %0d need 88098", out_cw); end
        ack();
    endtask

    task automatic test_range();
        int lat;
        run_word(43'd15149, lat);
        checks++; if (lat !== 61) begin errors++; $display("FAIL range_lat: got %0d need 61", lat); end
        checks++; if (out_rem !== 15'd15149) begin errors++; $display("FAIL range_rem: got %0d need 15149", out_rem); end
        checks++; if (out_status !== 2'b11 || out_loc !== 7'd16) begin errors++;
            $display("FAIL range_st: got st=%b loc=%0d need 11 16", out_status, out_loc); end
        checks++; if (out_cw !== 43'd15149) begin errors++; $display("FAIL range_cw: got %0d need 15149", out_cw); end
        ack();
    endtask

    task automatic test_reset_mid();
        int lat;
        int w;
        w = 0;
        while (!in_ready && w < 200) begin @(posedge clk); #1; w++; end
        in_valid = 1; in_cw = 43'd88098;
        @(posedge clk); #1;
        in_valid = 0;
        // cycles T+44..T+86 are SEARCH for this word
        repeat (55) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin errors++;
            $display("FAIL mid_busy: got v=%b rdy=%b need 0 0", out_valid, in_ready); end
        rst = 1;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_cw !== '0 || out_loc !== '0 ||
            out_rem !== '0 || out_status !== 2'b00) begin
            errors++;
            $display("FAIL mid_reset: v=%b rdy=%b cw=%0d loc=%0d rem=%0d st=%b, need 0 1 0 0 0 00",
                     out_valid, in_ready, out_cw, out_loc, out_rem, out_status);
        end
        rst = 0;
        @(posedge clk); #1;
        run_word(43'd88094, lat);
        checks++; if (lat !== 46 || out_cw !== 43'd88095 || out_status !== 2'b01 || out_loc !== 7'h7f) begin
            errors++;
            $display("FAIL after_reset: got lat=%0d cw=%0d st=%b loc=%h need 46 88095 01 7f",
                     lat, out_cw, out_status, out_loc);
        end
        ack();
    endtask

    task automatic test_back_to_back();
        int lat;
        run_word(43'd88095, lat);
        // offer next word during the output handshake; it must not be taken yet
        out_ready = 1; in_valid = 1; in_cw = 43'd120863;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_rdy: got %b need 0", in_ready); end
        @(posedge clk); #1;
        out_ready = 0;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++;
            $display("FAIL b2b_idle: got rdy=%b v=%b need 1 0", in_ready, out_valid); end
        @(posedge clk); #1;
        in_valid = 0;
        lat = 1;
        while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
        checks++; if (lat !== 61 || out_cw !== 43'd88095 || out_loc !== 7'd16 || out_status !== 2'b01) begin
            errors++;
            $display("FAIL b2b_second: got lat=%0d cw=%0d loc=%0d st=%b need 61 88095 16 01",
                     lat, out_cw, out_loc, out_status);
        end
        ack();
    endtask

    initial begin
        test_reset();
        test_clean();
        test_pos_error();
        test_neg_error();
        test_nomatch();
        test_range();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
